// File: rtl/sreg_bus_arbiter_pkg.sv
// Shared types for the system-register bus arbiter: state encoding, requester
// indices and the packed request payload.
package sreg_bus_arbiter_pkg;

   localparam int unsigned SREG_VAL_WIDTH = 64;
   localparam int unsigned SREG_GROUP_W   = 5;
   localparam int unsigned SREG_REGNUM_W  = 3;
   localparam int unsigned SREG_PLEVEL_W  = 2;
   localparam int unsigned SREG_NREQ      = 2;

   localparam int unsigned SREG_REQ_PIPE = 0;
   localparam int unsigned SREG_REQ_DBG  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic                      wr;
      logic [SREG_GROUP_W-1:0]   group;
      logic [SREG_REGNUM_W-1:0]  regnum;
      logic [SREG_PLEVEL_W-1:0]  plevel;
      logic [SREG_VAL_WIDTH-1:0] wval;
   } sreg_req_t;

endpackage

// File: rtl/sreg_prio_starve_pick.sv
// Two-way priority picker: pipeline wins ties unless debug has lost
// STARVE_LIMIT consecutive arbitrations.
module sreg_prio_starve_pick
   import sreg_bus_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arb_en,
   input  logic [1:0] valid,
   output logic [1:0] grant_c
);

   localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [CNT_W-1:0] starve_q;
   logic             starved_c;

   assign starved_c = (starve_q == CNT_W'(STARVE_LIMIT));

   // One-hot grant, only while the arbiter is free to accept
   always_comb begin
      grant_c = 2'b00;
      if (arb_en) begin
         if (valid == 2'b11) begin
            grant_c = starved_c ? 2'b10 : 2'b01;
         end else begin
            grant_c = valid;
         end
      end
   end

   // Consecutive debug losses; saturates at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else if (!valid[SREG_REQ_DBG]) begin
         starve_q <= '0;
      end else if (arb_en) begin
         if (grant_c[SREG_REQ_DBG]) begin
            starve_q <= '0;
         end else if (!starved_c) begin
            starve_q <= starve_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sreg_bus_arbiter.sv
// Arbitrates the single sysreg bus port between pipeline and debug, one
// transaction at a time with a read timeout. SREG_BUS_ARBITER_STATS_EN adds
// grant/timeout counters.
module sreg_bus_arbiter
   import sreg_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned VAL_WIDTH      = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [1:0]                req_wr,
   input  logic [1:0][4:0]           req_group,
   input  logic [1:0][2:0]           req_regnum,
   input  logic [1:0][1:0]           req_plevel,
   input  logic [1:0][VAL_WIDTH-1:0] req_wval,
   output logic [1:0]                rsp_valid,
   output logic                      rsp_err,
   output logic [VAL_WIDTH-1:0]      rsp_rval,
   output logic                      bus_rd_en,
   output logic                      bus_wr_en,
   output logic [4:0]                bus_group,
   output logic [2:0]                bus_regnum,
   output logic [1:0]                bus_plevel,
   output logic [VAL_WIDTH-1:0]      bus_wr_val,
   input  logic                      bus_rd_valid,
   input  logic [VAL_WIDTH-1:0]      bus_rd_val,
`ifdef SREG_BUS_ARBITER_STATS_EN
   output logic [31:0]               stat_grants0,
   output logic [31:0]               stat_grants1,
   output logic [31:0]               stat_timeouts,
`endif
   output logic                      busy
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

   arb_state_t       state_q, state_d;
   logic             owner_q, owner_d;
   logic             wr_q, wr_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic [1:0]       grant_c;
   logic             arb_en_c;
   logic             sel_c;
   logic [1:0]       owner_oh_c;
   sreg_req_t        cand_c;

   logic                 rd_en_d, wr_en_d, rsp_err_d, busy_d;
   logic [1:0]           rsp_valid_d;
   logic [VAL_WIDTH-1:0] rsp_rval_d, wval_d;
   logic [4:0]           group_d;
   logic [2:0]           regnum_d;
   logic [1:0]           plevel_d;

   assign arb_en_c   = (state_q == IDLE) && rst_n;
   assign req_ready  = grant_c;
   assign sel_c      = grant_c[SREG_REQ_DBG];
   assign owner_oh_c = owner_q ? 2'b10 : 2'b01;

   sreg_prio_starve_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .clk     (clk),
      .rst_n   (rst_n),
      .arb_en  (arb_en_c),
      .valid   (req_valid),
      .grant_c (grant_c)
   );

   // Winner's request fields
   always_comb begin
      cand_c        = '0;
      cand_c.wr     = req_wr[sel_c];
      cand_c.group  = req_group[sel_c];
      cand_c.regnum = req_regnum[sel_c];
      cand_c.plevel = req_plevel[sel_c];
      cand_c.wval   = SREG_VAL_WIDTH'(req_wval[sel_c]);
   end

   // Next state plus next value of every registered output
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      wr_d        = wr_q;
      tmo_d       = tmo_q;
      rd_en_d     = 1'b0;
      wr_en_d     = 1'b0;
      group_d     = '0;
      regnum_d    = '0;
      plevel_d    = '0;
      wval_d      = '0;
      rsp_valid_d = 2'b00;
      rsp_err_d   = 1'b0;
      rsp_rval_d  = '0;
      busy_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|grant_c) begin
               state_d  = ISSUE;
               owner_d  = sel_c;
               wr_d     = cand_c.wr;
               wr_en_d  = cand_c.wr;
               rd_en_d  = !cand_c.wr;
               group_d  = cand_c.group;
               regnum_d = cand_c.regnum;
               plevel_d = cand_c.plevel;
               wval_d   = VAL_WIDTH'(cand_c.wval);
               busy_d   = 1'b1;
            end
         end
         ISSUE: begin
            busy_d = 1'b1;
            if (wr_q) begin
               state_d     = RESP;
               rsp_valid_d = owner_oh_c;
            end else begin
               state_d  = WAIT;
               tmo_d    = '0;
               rd_en_d  = 1'b1;
               group_d  = bus_group;
               regnum_d = bus_regnum;
               plevel_d = bus_plevel;
               wval_d   = bus_wr_val;
            end
         end
         WAIT: begin
            busy_d = 1'b1;
            if (bus_rd_valid) begin
               state_d     = RESP;
               rsp_valid_d = owner_oh_c;
               rsp_rval_d  = bus_rd_val;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               state_d     = RESP;
               rsp_valid_d = owner_oh_c;
               rsp_err_d   = 1'b1;
            end else begin
               tmo_d    = tmo_q + TMO_W'(1);
               rd_en_d  = 1'b1;
               group_d  = bus_group;
               regnum_d = bus_regnum;
               plevel_d = bus_plevel;
               wval_d   = bus_wr_val;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         wr_q       <= 1'b0;
         tmo_q      <= '0;
         bus_rd_en  <= 1'b0;
         bus_wr_en  <= 1'b0;
         bus_group  <= '0;
         bus_regnum <= '0;
         bus_plevel <= '0;
         bus_wr_val <= '0;
         rsp_valid  <= 2'b00;
         rsp_err    <= 1'b0;
         rsp_rval   <= '0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wr_q       <= wr_d;
         tmo_q      <= tmo_d;
         bus_rd_en  <= rd_en_d;
         bus_wr_en  <= wr_en_d;
         bus_group  <= group_d;
         bus_regnum <= regnum_d;
         bus_plevel <= plevel_d;
         bus_wr_val <= wval_d;
         rsp_valid  <= rsp_valid_d;
         rsp_err    <= rsp_err_d;
         rsp_rval   <= rsp_rval_d;
         busy       <= busy_d;
      end
   end

`ifdef SREG_BUS_ARBITER_STATS_EN
   // Free-running event counters, wrap at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grants0  <= '0;
         stat_grants1  <= '0;
         stat_timeouts <= '0;
      end else begin
         if (req_ready[SREG_REQ_PIPE]) stat_grants0 <= stat_grants0 + 32'd1;
         if (req_ready[SREG_REQ_DBG])  stat_grants1 <= stat_grants1 + 32'd1;
         if ((rsp_valid != 2'b00) && rsp_err) stat_timeouts <= stat_timeouts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sreg_bus_arbiter.sv
// Directed self-checking bench for sreg_bus_arbiter (default parameters).
// Stat counters are checked when SREG_BUS_ARBITER_STATS_EN is defined.
module tb_sreg_bus_arbiter;

   localparam int unsigned TIMEOUT_CYCLES = 16;
   localparam int unsigned VW = 64;

   logic                clk;
   logic                rst_n;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_wr;
   logic [1:0][4:0]     req_group;
   logic [1:0][2:0]     req_regnum;
   logic [1:0][1:0]     req_plevel;
   logic [1:0][VW-1:0]  req_wval;
   logic [1:0]          rsp_valid;
   logic                rsp_err;
   logic [VW-1:0]       rsp_rval;
   logic                bus_rd_en;
   logic                bus_wr_en;
   logic [4:0]          bus_group;
   logic [2:0]          bus_regnum;
   logic [1:0]          bus_plevel;
   logic [VW-1:0]       bus_wr_val;
   logic                bus_rd_valid;
   logic [VW-1:0]       bus_rd_val;
   logic                busy;
`ifdef SREG_BUS_ARBITER_STATS_EN
   logic [31:0]         stat_grants0;
   logic [31:0]         stat_grants1;
   logic [31:0]         stat_timeouts;
`endif

   int n_checks;
   int n_fail;

   sreg_bus_arbiter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .STARVE_LIMIT   (4),
      .VAL_WIDTH      (VW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_wr        (req_wr),
      .req_group     (req_group),
      .req_regnum    (req_regnum),
      .req_plevel    (req_plevel),
      .req_wval      (req_wval),
      .rsp_valid     (rsp_valid),
      .rsp_err       (rsp_err),
      .rsp_rval      (rsp_rval),
      .bus_rd_en     (bus_rd_en),
      .bus_wr_en     (bus_wr_en),
      .bus_group     (bus_group),
      .bus_regnum    (bus_regnum),
      .bus_plevel    (bus_plevel),
      .bus_wr_val    (bus_wr_val),
      .bus_rd_valid  (bus_rd_valid),
      .bus_rd_val    (bus_rd_val),
`ifdef SREG_BUS_ARBITER_STATS_EN
      .stat_grants0  (stat_grants0),
      .stat_grants1  (stat_grants1),
      .stat_timeouts (stat_timeouts),
`endif
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One uncontended transaction; k = WAIT cycle carrying read data, k < 0 = never
   task automatic run_txn(input string tag, input int who, input logic wr,
                          input logic [4:0] grp, input logic [2:0] rn, input logic [1:0] pl,
                          input logic [63:0] wv, input int k, input logic [63:0] rdata);
      logic [1:0] oh;
      int         n_wait;
      oh = (who == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      req_valid       = oh;
      req_wr[who]     = wr;
      req_group[who]  = grp;
      req_regnum[who] = rn;
      req_plevel[who] = pl;
      req_wval[who]   = wv;
      #1;
      check($sformatf("%s_ready", tag), 64'(req_ready), 64'(oh));
      // ISSUE cycle; stray read data here must be ignored
      @(negedge clk);
      req_valid    = 2'b00;
      bus_rd_valid = 1'b1;
      bus_rd_val   = ~rdata;
      check($sformatf("%s_wr_en", tag), 64'(bus_wr_en), 64'(wr));
      check($sformatf("%s_rd_en", tag), 64'(bus_rd_en), 64'(!wr));
      check($sformatf("%s_group", tag), 64'(bus_group), 64'(grp));
      check($sformatf("%s_regnum", tag), 64'(bus_regnum), 64'(rn));
      check($sformatf("%s_plevel", tag), 64'(bus_plevel), 64'(pl));
      check($sformatf("%s_wval", tag), bus_wr_val, wv);
      check($sformatf("%s_busy", tag), 64'(busy), 64'd1);
      if (!wr) begin
         n_wait = (k < 0) ? int'(TIMEOUT_CYCLES) : k + 1;
         for (int c = 0; c < n_wait; c++) begin
            @(negedge clk);
            bus_rd_valid = (c == k);
            bus_rd_val   = (c == k) ? rdata : ~rdata;
            check($sformatf("%s_wait%0d_rsp", tag, c), 64'(rsp_valid), 64'd0);
         end
         check($sformatf("%s_wait_rd_en", tag), 64'(bus_rd_en), 64'd1);
         check($sformatf("%s_wait_group", tag), 64'(bus_group), 64'(grp));
      end
      // RESP cycle
      @(negedge clk);
      bus_rd_valid = 1'b0;
      bus_rd_val   = '0;
      check($sformatf("%s_rsp_valid", tag), 64'(rsp_valid), 64'(oh));
      check($sformatf("%s_rsp_err", tag), 64'(rsp_err), 64'(!wr && k < 0));
      check($sformatf("%s_rsp_rval", tag), rsp_rval, (wr || k < 0) ? 64'd0 : rdata);
      check($sformatf("%s_rsp_bus_idle", tag), 64'({bus_rd_en, bus_wr_en, bus_group}), 64'd0);
      @(negedge clk);
      check($sformatf("%s_done", tag), 64'({rsp_valid, busy}), 64'd0);
   endtask

   logic [1:0] exp_seq [10];
   int         ng;
   int         last;
   logic       seen;

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      clk          = 1'b0;
      rst_n        = 1'b0;
      req_valid    = '0;
      req_wr       = '0;
      req_group    = '0;
      req_regnum   = '0;
      req_plevel   = '0;
      req_wval     = '0;
      bus_rd_valid = 1'b0;
      bus_rd_val   = '0;
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

      #1;
      check("rst_outputs", 64'({rsp_valid, rsp_err, bus_rd_en, bus_wr_en, bus_group, bus_regnum, bus_plevel, busy}), 64'd0);
      check("rst_rval", rsp_rval, 64'd0);
      check("rst_wr_val", bus_wr_val, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", 64'(req_ready), 64'd0);

      // Pipeline read, data two cycles into WAIT
      run_txn("p_rd", 0, 1'b0, 5'd3, 3'd7, 2'd0, 64'd0, 2, 64'h1234_5678_9ABC_DEF0);
      // Debug write
      run_txn("d_wr", 1, 1'b1, 5'd10, 3'd2, 2'd3, 64'hA5, -1, 64'd0);
      // Read to a silent node, then an immediate follow-up
      run_txn("p_tmo", 0, 1'b0, 5'd1, 3'd4, 2'd1, 64'd0, -1, 64'd0);
      run_txn("d_rd_k0", 1, 1'b0, 5'd31, 3'd0, 2'd2, 64'd0, 0, 64'hFEED_0000_0000_BEEF);

      // Both requesters held continuously (writes)
      @(negedge clk);
      req_valid = 2'b11;
      req_wr    = 2'b11;
      ng   = 0;
      last = 0;
      for (int c = 0; c < 60 && ng < 10; c++) begin
         #1;
         if (req_ready != 2'b00) begin
            check($sformatf("starve_grant%0d", ng), 64'(req_ready), 64'(exp_seq[ng]));
            if (ng > 0) check($sformatf("starve_gap%0d", ng), 64'(c - last), 64'd3);
            last = c;
            ng++;
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      check("starve_grants", 64'(ng), 64'd10);
      repeat (3) @(negedge clk);
      check("starve_idle", 64'({busy, rsp_valid}), 64'd0);

      // Reset during WAIT
      @(negedge clk);
      req_valid       = 2'b01;
      req_wr[0]       = 1'b0;
      req_group[0]    = 5'd4;
      req_regnum[0]   = 3'd5;
      #1;
      check("rstw_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      check("rstw_in_wait", 64'(bus_rd_en), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstw_async", 64'({rsp_valid, rsp_err, bus_rd_en, bus_wr_en, bus_group, bus_regnum, busy}), 64'd0);
      bus_rd_valid = 1'b1;
      bus_rd_val   = 64'h5555;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid != 2'b00 || busy) seen = 1'b1;
      end
      bus_rd_valid = 1'b0;
      bus_rd_val   = '0;
      check("rstw_no_rsp", 64'(seen), 64'd0);

      run_txn("post_rst_d_wr", 1, 1'b1, 5'd6, 3'd1, 2'd0, 64'hC0DE, -1, 64'd0);
      run_txn("post_rst_p_rd1", 0, 1'b0, 5'd2, 3'd3, 2'd1, 64'd0, 1, 64'h0000_0001_0000_0002);
      run_txn("post_rst_p_rd2", 0, 1'b0, 5'd9, 3'd6, 2'd2, 64'd0, 4, 64'h8000_0000_0000_0001);
      run_txn("post_rst_p_tmo", 0, 1'b0, 5'd17, 3'd7, 2'd3, 64'd0, -1, 64'd0);

`ifdef SREG_BUS_ARBITER_STATS_EN
      check("stat_grants0", 64'(stat_grants0), 64'd3);
      check("stat_grants1", 64'(stat_grants1), 64'd1);
      check("stat_timeouts", 64'(stat_timeouts), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
